// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Run-control states, fixed instruction encodings and PC alignment helper.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN   = 32'h00000013;
    localparam logic [31:0] ECALL_INSN = 32'h00000073;
    localparam logic [63:0] ALIGN_MASK = 64'h3;

    function automatic logic is_aligned(input logic [63:0] addr);
        return (addr & ALIGN_MASK) == 64'd0;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage and its environment.
// Ports: program load, run control, branch redirect in; instruction/pc/status out.
interface instruction_fetch_if #(
    parameter int IMEM_DEPTH = 256
) ();
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic          stall;
    logic          branch_taken;
    logic [63:0]   branch_target;
    logic [31:0]   instruction;
    logic [63:0]   pc;
    logic          instr_valid;
    logic          halted;
    logic          fault;

    modport master (
        output load_en, load_addr, load_data,
        output start, stall, branch_taken, branch_target,
        input  instruction, pc, instr_valid, halted, fault
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  start, stall, branch_taken, branch_target,
        output instruction, pc, instr_valid, halted, fault
    );

endinterface

// File: rtl/instruction_memory.sv
// Instruction store: DEPTH x 32, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module instruction_memory #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // No reset: the loaded program must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection and run-control FSM.
// Ports: clk, reset (async, active-low), bus (instruction_fetch_if.slave).
module instruction_fetch
    import rv_fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input logic               clk,
    input logic               reset,
    instruction_fetch_if.slave bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_t state;
    logic [63:0]  pc_q;
    logic         halted_q;
    logic         fault_q;
    logic [31:0]  rdata;
    logic         in_range;
    logic         valid;
    logic         mem_we;

    // Depth is a power of two, so "word index < depth" means
    // every PC bit above the memory index is zero.
    assign in_range = (pc_q[63:AW+2] == '0) && is_aligned(pc_q);
    assign valid    = (state == RUN) && in_range;
    assign mem_we   = (state == IDLE) && bus.load_en;

    instruction_memory #(
        .DEPTH(IMEM_DEPTH)
    ) u_imem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(bus.load_addr),
        .wdata(bus.load_data),
        .raddr(pc_q[AW+1:2]),
        .rdata(rdata)
    );

    assign bus.instruction = valid ? rdata : NOP_INSN;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = valid;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A load in the same cycle wins over start.
                    if (!bus.load_en && bus.start) begin
                        state <= RUN;
                        pc_q  <= RESET_PC;
                    end
                end
                RUN: begin
                    if (!in_range) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else if (!bus.stall) begin
                        // Stall outranks ECALL: a stalled ECALL does not halt.
                        if (rdata == ECALL_INSN) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end else if (bus.branch_taken) begin
                            pc_q <= bus.branch_target;
                            if (!is_aligned(bus.branch_target)) begin
                                state   <= FAULT;
                                fault_q <= 1'b1;
                            end
                        end else begin
                            pc_q <= pc_q + 64'd4;
                        end
                    end
                end
                HALT, FAULT: begin
                    if (bus.start) begin
                        state    <= IDLE;
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI2 = 32'h00200113;
    localparam logic [31:0] ADDI3 = 32'h00300193;
    localparam logic [31:0] ADDI4 = 32'h00400213;
    localparam logic [31:0] ADDI5 = 32'h00500293;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.IMEM_DEPTH(16)) bus ();
    instruction_fetch_if #(.IMEM_DEPTH(4))  bus4 ();

    instruction_fetch #(
        .IMEM_DEPTH(16),
        .RESET_PC  (64'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    instruction_fetch #(
        .IMEM_DEPTH(4),
        .RESET_PC  (64'h0)
    ) dut4 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus4)
    );

    // Reference model: mode 0=idle 1=run 2=halt 3=fault
    int          m_mode;
    logic [63:0] m_pc;
    logic [31:0] m_mem [16];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_en       = 1'b0;
        bus.load_addr     = '0;
        bus.load_data     = '0;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus4.load_en       = 1'b0;
        bus4.load_addr     = '0;
        bus4.load_data     = '0;
        bus4.start         = 1'b0;
        bus4.stall         = 1'b0;
        bus4.branch_taken  = 1'b0;
        bus4.branch_target = '0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        cyc();
        bus.load_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic go_idle();
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault}
            !== {64'h0, NOP, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h",
                     {bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault},
                     {64'h0, NOP, 3'b000});
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_program();
        logic [31:0] prog [3];
        prog[0] = ADDI1;
        prog[1] = ADDI2;
        prog[2] = ECALL;
        for (int i = 0; i < 16; i++) load_word(4'(i), NOP);
        for (int i = 0; i < 3; i++) load_word(4'(i), prog[i]);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({bus.pc, bus.instr_valid, bus.instruction, bus.halted}
                !== {64'(k * 4), 1'b1, prog[k], 1'b0}) begin
                n_fail++;
                $display("FAIL prog_step%0d: got %h want %h", k,
                         {bus.pc, bus.instr_valid, bus.instruction, bus.halted},
                         {64'(k * 4), 1'b1, prog[k], 1'b0});
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({bus.pc, bus.instr_valid, bus.instruction, bus.halted, bus.fault}
                !== {64'h8, 1'b0, NOP, 2'b10}) begin
                n_fail++;
                $display("FAIL prog_halt%0d: got %h want %h", k,
                         {bus.pc, bus.instr_valid, bus.instruction, bus.halted, bus.fault},
                         {64'h8, 1'b0, NOP, 2'b10});
            end
            cyc();
        end
        pulse_start();
        n_checks++;
        if ({bus.instr_valid, bus.halted, bus.fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL halt_to_idle: got %b want 000",
                     {bus.instr_valid, bus.halted, bus.fault});
        end
    endtask

    task automatic test_stall();
        pulse_start();
        cyc();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if ({bus.pc, bus.instr_valid} !== {64'h4, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc %h v %b want pc 4 v 1",
                         k, bus.pc, bus.instr_valid);
            end
        end
        bus.stall = 1'b0;
        cyc();
        n_checks++;
        if ({bus.pc, bus.instruction} !== {64'h8, ECALL}) begin
            n_fail++;
            $display("FAIL stall_release: got %h want %h",
                     {bus.pc, bus.instruction}, {64'h8, ECALL});
        end
        bus.stall = 1'b1;
        cyc();
        n_checks++;
        if ({bus.pc, bus.halted, bus.instr_valid} !== {64'h8, 2'b01}) begin
            n_fail++;
            $display("FAIL stall_over_ecall: got %h want %h",
                     {bus.pc, bus.halted, bus.instr_valid}, {64'h8, 2'b01});
        end
        bus.stall = 1'b0;
        cyc();
        n_checks++;
        if ({bus.pc, bus.halted} !== {64'h8, 1'b1}) begin
            n_fail++;
            $display("FAIL ecall_after_stall: got %h want %h",
                     {bus.pc, bus.halted}, {64'h8, 1'b1});
        end
        pulse_start();
    endtask

    task automatic test_branch();
        load_word(4'd2, NOP);
        pulse_start();
        cyc();
        cyc();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h20;
        cyc();
        n_checks++;
        if ({bus.pc, bus.instr_valid, bus.fault} !== {64'h20, 2'b10}) begin
            n_fail++;
            $display("FAIL branch_aligned: got %h want %h",
                     {bus.pc, bus.instr_valid, bus.fault}, {64'h20, 2'b10});
        end
        bus.branch_target = 64'h8;
        cyc();
        bus.branch_target = 64'h22;
        cyc();
        n_checks++;
        if ({bus.pc, bus.fault, bus.instr_valid} !== {64'h22, 2'b10}) begin
            n_fail++;
            $display("FAIL branch_misaligned: got %h want %h",
                     {bus.pc, bus.fault, bus.instr_valid}, {64'h22, 2'b10});
        end
        bus.branch_target = 64'h0;
        cyc();
        n_checks++;
        if ({bus.pc, bus.fault} !== {64'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL fault_ignores_branch: got %h want %h",
                     {bus.pc, bus.fault}, {64'h22, 1'b1});
        end
        bus.branch_taken = 1'b0;
        pulse_start();
        n_checks++;
        if ({bus.fault, bus.halted, bus.instr_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL fault_to_idle: got %b want 000",
                     {bus.fault, bus.halted, bus.instr_valid});
        end
    endtask

    task automatic test_runoff();
        for (int i = 0; i < 4; i++) begin
            bus4.load_en   = 1'b1;
            bus4.load_addr = 2'(i);
            bus4.load_data = NOP;
            cyc();
        end
        bus4.load_en = 1'b0;
        bus4.start   = 1'b1;
        cyc();
        bus4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus4.pc, bus4.instr_valid} !== {64'(k * 4), 1'b1}) begin
                n_fail++;
                $display("FAIL runoff_step%0d: got %h want %h", k,
                         {bus4.pc, bus4.instr_valid}, {64'(k * 4), 1'b1});
            end
            cyc();
        end
        n_checks++;
        if ({bus4.pc, bus4.instr_valid, bus4.instruction, bus4.fault}
            !== {64'h10, 1'b0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL runoff_edge: got %h want %h",
                     {bus4.pc, bus4.instr_valid, bus4.instruction, bus4.fault},
                     {64'h10, 1'b0, NOP, 1'b0});
        end
        cyc();
        n_checks++;
        if ({bus4.pc, bus4.fault, bus4.instr_valid} !== {64'h10, 2'b10}) begin
            n_fail++;
            $display("FAIL runoff_fault: got %h want %h",
                     {bus4.pc, bus4.fault, bus4.instr_valid}, {64'h10, 2'b10});
        end
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        load_word(4'd0, ADDI1);
        load_word(4'd1, ADDI2);
        load_word(4'd2, ADDI3);
        load_word(4'd3, ADDI4);
        pulse_start();
        cyc();
        cyc();
        n_checks++;
        if ({bus.pc, bus.instruction} !== {64'h8, ADDI3}) begin
            n_fail++;
            $display("FAIL midrun_pre: got %h want %h",
                     {bus.pc, bus.instruction}, {64'h8, ADDI3});
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault}
            !== {64'h0, NOP, 3'b000}) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %h want %h",
                     {bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault},
                     {64'h0, NOP, 3'b000});
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
        pulse_start();
        n_checks++;
        if ({bus.pc, bus.instr_valid, bus.instruction} !== {64'h0, 1'b1, ADDI1}) begin
            n_fail++;
            $display("FAIL mem_survives_0: got %h want %h",
                     {bus.pc, bus.instr_valid, bus.instruction}, {64'h0, 1'b1, ADDI1});
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'hc;
        cyc();
        bus.branch_taken = 1'b0;
        n_checks++;
        if ({bus.pc, bus.instruction} !== {64'hc, ADDI4}) begin
            n_fail++;
            $display("FAIL mem_survives_3: got %h want %h",
                     {bus.pc, bus.instruction}, {64'hc, ADDI4});
        end
        go_idle();
    endtask

    task automatic test_load_start();
        bus.load_en   = 1'b1;
        bus.start     = 1'b1;
        bus.load_addr = 4'd5;
        bus.load_data = ADDI5;
        cyc();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        n_checks++;
        if ({bus.pc, bus.instr_valid, bus.halted, bus.fault} !== {64'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL load_beats_start: got %h want %h",
                     {bus.pc, bus.instr_valid, bus.halted, bus.fault}, {64'h0, 3'b000});
        end
        pulse_start();
        n_checks++;
        if ({bus.pc, bus.instr_valid, bus.instruction} !== {64'h0, 1'b1, ADDI1}) begin
            n_fail++;
            $display("FAIL start_after_load: got %h want %h",
                     {bus.pc, bus.instr_valid, bus.instruction}, {64'h0, 1'b1, ADDI1});
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h14;
        cyc();
        bus.branch_taken = 1'b0;
        n_checks++;
        if ({bus.pc, bus.instruction} !== {64'h14, ADDI5}) begin
            n_fail++;
            $display("FAIL loaded_word_read: got %h want %h",
                     {bus.pc, bus.instruction}, {64'h14, ADDI5});
        end
        go_idle();
    endtask

    function automatic logic [31:0] rand_word();
        int          r = $urandom_range(0, 9);
        logic [31:0] w;
        w      = $urandom();
        w[6:0] = 7'h13;
        if (r == 0) return ECALL;
        if (r < 4)  return NOP;
        return w;
    endfunction

    // Spec rules applied to the model at one clock edge.
    task automatic model_step(input logic ld, input logic [3:0] a,
                              input logic [31:0] d, input logic st,
                              input logic sl, input logic br,
                              input logic [63:0] t);
        logic inr;
        inr = (m_pc % 4 == 0) && (m_pc < 64);
        case (m_mode)
            0: begin
                if (ld) m_mem[a] = d;
                else if (st) begin
                    m_mode = 1;
                    m_pc   = 0;
                end
            end
            1: begin
                if (!inr) m_mode = 3;
                else if (!sl) begin
                    if (m_mem[m_pc / 4] == ECALL) m_mode = 2;
                    else if (br) begin
                        m_pc = t;
                        if (t % 4 != 0) m_mode = 3;
                    end else m_pc = m_pc + 4;
                end
            end
            default: if (st) m_mode = 0;
        endcase
    endtask

    task automatic test_random();
        logic        ld, st, sl, br, e_valid;
        logic [3:0]  a;
        logic [31:0] d, e_instr;
        logic [63:0] t;
        int          r;
        go_idle();
        m_mode = 0;
        m_pc   = 0;
        for (int n = 0; n < 616; n++) begin
            a  = 4'($urandom_range(0, 15));
            d  = rand_word();
            ld = (n < 16) || ($urandom_range(0, 7) == 0);
            if (n < 16) a = 4'(n);
            st = (n >= 16) && ($urandom_range(0, 5) == 0);
            sl = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 4) == 0);
            r  = $urandom_range(0, 9);
            t  = 64'($urandom_range(0, 15)) * 4;
            if (r == 7) t = t + 64'($urandom_range(1, 3));
            if (r == 8) t = t + 64'h40;
            if (r == 9) t = {32'($urandom()), 32'($urandom())} & ~64'h3;
            bus.load_en       = ld;
            bus.load_addr     = a;
            bus.load_data     = d;
            bus.start         = st;
            bus.stall         = sl;
            bus.branch_taken  = br;
            bus.branch_target = t;
            model_step(ld, a, d, st, sl, br, t);
            cyc();
            e_valid = (m_mode == 1) && (m_pc % 4 == 0) && (m_pc < 64);
            e_instr = e_valid ? m_mem[m_pc / 4] : NOP;
            n_checks++;
            if ({bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault}
                !== {m_pc, e_instr, e_valid, m_mode == 2, m_mode == 3}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h want %h", n,
                         {bus.pc, bus.instruction, bus.instr_valid, bus.halted, bus.fault},
                         {m_pc, e_instr, e_valid, m_mode == 2, m_mode == 3});
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_branch();
        test_runoff();
        test_reset_midrun();
        test_load_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the instruction parser and register file. Holds the program counter, a loadable instruction memory and a small run-control state machine. Presents one 32-bit instruction per cycle on `instruction` to the parser and advances the PC by +4 or to a branch target supplied from downstream. Stops on ECALL or on a fetch fault.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory size in 32-bit words; power of two, at least 4.
- `RESET_PC`, 64'h0: PC value after reset and on every `start`; must be 4-byte aligned.

Ports:
- `clk`, in, 1: single clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-low. Low clears all state immediately.
- `load_en`, in, 1: program-load write strobe. Honoured in IDLE only.
- `load_addr`, in, log2(IMEM_DEPTH): word address for the load.
- `load_data`, in, 32: instruction word to write.
- `start`, in, 1: IDLE → RUN; HALT/FAULT → IDLE.
- `stall`, in, 1: hold PC this cycle.
- `branch_taken`, in, 1: redirect PC to `branch_target` at the next edge.
- `branch_target`, in, 64: redirect address.
- `instruction`, out, 32: instruction at `pc`; NOP 32'h00000013 when `instr_valid`=0.
- `pc`, out, 64: current program counter.
- `instr_valid`, out, 1: `instruction` is a real fetched word.
- `halted`, out, 1: high in HALT.
- `fault`, out, 1: high in FAULT.

## Operation
- States are IDLE, RUN, HALT and FAULT.
- Reset values:
  - state is IDLE and `pc` is RESET_PC.
  - `instruction` is the NOP, and `instr_valid`, `halted` and `fault` are 0.
  - Memory contents are not cleared and survive reset.
- IDLE:
  - When `load_en`=1, `imem[load_addr]` ← `load_data` at the edge.
  - When `start`=1 and `load_en`=0, go to RUN and set `pc` ← RESET_PC.
  - If `load_en` and `start` are both high, the write happens and `start` is ignored.
- RUN: `instr_valid`=1 unless the PC is out of range. Next-PC priority is evaluated each edge, first match wins:
  1. If `pc[63:2]` ≥ IMEM_DEPTH or `pc[1:0]`≠0, go to FAULT and hold `pc`. `instr_valid`=0 in this cycle.
  2. If `stall`=1, hold `pc` and the state, even when the current instruction is ECALL.
  3. If `instruction`==32'h00000073 (ECALL), go to HALT and hold `pc`.
  4. If `branch_taken`=1:
     - if `branch_target[1:0]`≠0, go to FAULT and `pc` ← `branch_target`;
     - otherwise `pc` ← `branch_target`.
  5. Otherwise `pc` ← `pc`+4, modulo 2^64. The range check in rule 1 catches any run-off.
- RUN ignores `load_en`.
- HALT and FAULT:
  - `instr_valid`=0 and `pc` is held.
  - `start` returns to IDLE; `pc` is reloaded on the next `start` from IDLE.
  - `stall` and branch inputs are ignored.
- Memory indexing uses `pc[log2(IMEM_DEPTH)+1:2]`.

## Timing
- Instruction read is combinational from `pc`: zero-cycle latency, matching the single-cycle datapath.
- `pc`, state and memory writes update on the rising edge of `clk`.
- A branch asserted in cycle N takes effect at `pc` in cycle N+1. There is no delay slot.
- A load write in cycle N is readable from cycle N+1.
- `reset` asserted mid-RUN forces IDLE and RESET_PC asynchronously. Deassertion is synchronised externally.
- `halted` and `fault` are registered state decodes and assert in the cycle after the triggering edge.

## Structure
- Package `rv_fetch_pkg` holds:
  - the state enum `fetch_state_t` (IDLE/RUN/HALT/FAULT);
  - the constants `NOP_INSN`=32'h00000013 and `ECALL_INSN`=32'h00000073;
  - the alignment mask.
- Sub-module `instruction_memory`: IMEM_DEPTH×32 array with a synchronous write port and an asynchronous read port.
- The top of `instruction_fetch` contains the PC register, the next-PC mux and the FSM.

## Test plan
- Load three words (ADDI, ADDI, ECALL) at addresses 0–2, then pulse `start`:
  - `pc` reads 0, 4 and 8 on successive cycles with `instr_valid`=1;
  - `halted`=1 from the cycle after `pc`=8, and `pc` stays 8.
- In RUN at `pc`=4, hold `stall`=1 for 3 cycles: `pc` stays 4 for 3 cycles, then continues at 8.
- In RUN at `pc`=8:
  - `branch_taken`=1 with `branch_target`=0x20 gives `pc`=0x20 on the next cycle;
  - `branch_target`=0x22 gives `fault`=1 and `pc`=0x22.
- With IMEM_DEPTH=4, run NOPs from 0: at `pc`=0x10 `instr_valid`=0 and the state moves to FAULT.
- Pull `reset` low mid-RUN at `pc`=0x8: `pc`=0 and IDLE immediately, `instruction`=NOP. After release, the previously loaded words are still readable after `start`.
- In IDLE, assert `load_en` and `start` together: the word is written and the state stays IDLE. A `start` alone on the next cycle enters RUN.
